// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 DIV/DIVU engine for the execute stage.
// Drives stall_req while iterating and returns {hi=remainder, lo=quotient}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall_req,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState;

  divState          state, nextState;
  logic [WIDTH:0]   remReg;
  logic [WIDTH-1:0] quotReg;
  logic [WIDTH-1:0] divisorReg;
  logic [CW-1:0]    counter;
  logic             quotNeg, remNeg;

  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH+1:0] shifted, diff;
  logic             trialGeq;
  logic [WIDTH:0]   trialRem;
  logic [WIDTH-1:0] trialQuot;

  // Magnitudes; |0x80000000| stays 0x80000000 when read as unsigned.
  assign absA = (signed_div && a[WIDTH-1]) ? -a : a;
  assign absB = (signed_div && b[WIDTH-1]) ? -b : b;

  // One restoring step: the sign of the trial difference picks the quotient bit.
  assign shifted   = {remReg, quotReg[WIDTH-1]};
  assign diff      = shifted - {2'b00, divisorReg};
  assign trialGeq  = ~diff[WIDTH+1];
  assign trialRem  = trialGeq ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign trialQuot = {quotReg[WIDTH-2:0], trialGeq};

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    nextState = state;
    stall_req = 1'b0;
    valid     = 1'b0;
    unique case (state)
      IDLE: if (start && !cancel) begin
        stall_req = 1'b1;
        nextState = (b == '0) ? DONE : BUSY;
      end
      BUSY: begin
        stall_req = !cancel;
        if (counter == LAST) nextState = DONE;
      end
      DONE: begin
        valid     = !cancel;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (cancel) nextState = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remReg     <= '0;
      quotReg    <= '0;
      divisorReg <= '0;
      counter    <= '0;
      quotNeg    <= 1'b0;
      remNeg     <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (!cancel) begin
      unique case (state)
        IDLE: if (start) begin
          counter <= '0;
          if (b == '0) begin
            lo <= '1;
            hi <= a;
          end else begin
            remReg     <= '0;
            quotReg    <= absA;
            divisorReg <= absB;
            quotNeg    <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            remNeg     <= signed_div & a[WIDTH-1];
          end
        end
        BUSY: begin
          remReg  <= trialRem;
          quotReg <= trialQuot;
          counter <= counter + 1'b1;
          // Last step: publish the sign-corrected result as DONE is entered.
          if (counter == LAST) begin
            lo <= quotNeg ? -trialQuot : trialQuot;
            hi <= remNeg ? -trialRem[WIDTH-1:0] : trialRem[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus randomized divides
// compared against an arithmetic reference model.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_div, cancel;
  logic [W-1:0] a, b;
  logic         stall_req, valid;
  logic [W-1:0] hi, lo;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] lastHi = '0;
  logic [W-1:0] lastLo = '0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .cancel(cancel),
    .stall_req(stall_req), .valid(valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi=remainder, lo=quotient}; signed math in 64 bits so MIN/-1 wraps.
  function automatic logic [2*W-1:0] ref_div(input bit sd, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    if (y == '0) return {x, {W{1'b1}}};
    if (sd) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[W-1:0], q[W-1:0]};
    end
    return {x % y, x / y};
  endfunction

  // One full divide with start held until valid; checks latency, stall span and result.
  task automatic test_op(input string tag, input bit sd, input logic [W-1:0] opA,
                         input logic [W-1:0] opB, input logic [W-1:0] expHi,
                         input logic [W-1:0] expLo);
    int lat, stalls, expLat;
    logic [W-1:0] gotHi, gotLo;
    expLat = (opB == '0) ? 1 : W + 1;
    lat = -1; stalls = 0; gotHi = '0; gotLo = '0;
    for (int cyc = 0; cyc <= 60 && lat < 0; cyc++) begin
      @(negedge clk);
      start = 1'b1; cancel = 1'b0;
      if (cyc == 0) begin
        signed_div = sd; a = opA; b = opB;
      end else begin
        signed_div = 1'($urandom); a = $urandom; b = $urandom;
      end
      #1;
      if (cyc == 0) begin
        vectors++;
        if ({hi, lo} !== {lastHi, lastLo}) begin
          miscompares++;
          $display("FAIL %s hold: hi/lo=%h/%h expected %h/%h", tag, hi, lo, lastHi, lastLo);
        end
      end
      if (stall_req) stalls++;
      if (valid) begin
        lat = cyc; gotHi = hi; gotLo = lo;
      end
    end
    vectors++;
    if (lat !== expLat) begin
      miscompares++;
      $display("FAIL %s latency: valid at cycle %0d expected %0d", tag, lat, expLat);
    end
    vectors++;
    if (stalls !== expLat) begin
      miscompares++;
      $display("FAIL %s stall: %0d stall cycles expected %0d", tag, stalls, expLat);
    end
    vectors++;
    if (gotLo !== expLo) begin
      miscompares++;
      $display("FAIL %s lo: got %h expected %h", tag, gotLo, expLo);
    end
    vectors++;
    if (gotHi !== expHi) begin
      miscompares++;
      $display("FAIL %s hi: got %h expected %h", tag, gotHi, expHi);
    end
    lastHi = expHi; lastLo = expLo;
  endtask

  // Quiet cycle after a result: no second valid, no stall, result held.
  task automatic test_idle(input string tag);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; a = $urandom; b = $urandom;
    #1;
    vectors++;
    if ({valid, stall_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s idle: valid/stall_req=%b%b expected 00", tag, valid, stall_req);
    end
    vectors++;
    if ({hi, lo} !== {lastHi, lastLo}) begin
      miscompares++;
      $display("FAIL %s idle hold: hi/lo=%h/%h expected %h/%h", tag, hi, lo, lastHi, lastLo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    #1;
    vectors++;
    if ({stall_req, valid, hi, lo} !== '0) begin
      miscompares++;
      $display("FAIL reset: stall_req=%b valid=%b hi=%h lo=%h expected all 0", stall_req, valid, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    lastHi = '0; lastLo = '0;
  endtask

  task automatic test_divu_basic();
    test_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    test_idle("divu_100_7");
  endtask

  task automatic test_signed();
    test_op("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    test_op("divu_m7_2",   1'b0, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC);
    test_op("div_min_m1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    test_op("div_7_m2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    test_idle("signed");
  endtask

  task automatic test_div_by_zero();
    test_op("divu_5_0",   1'b0, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF);
    test_op("div_min_0",  1'b1, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF);
    test_idle("div0");
  endtask

  task automatic test_cancel();
    // start & cancel together in IDLE is ignored.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; signed_div = 1'b0; a = 32'd50; b = 32'd3;
    #1;
    vectors++;
    if (stall_req !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_idle stall_req: got %b expected 0", stall_req);
    end
    test_idle("cancel_idle");
    // Cancel in BUSY cycle 10, then relaunch at cycle 11.
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b1; cancel = (cyc == 10);
      if (cyc == 0) begin
        signed_div = 1'b0; a = $urandom; b = $urandom | 32'd1;
      end
      #1;
      vectors++;
      if (valid !== 1'b0) begin
        miscompares++;
        $display("FAIL cancel valid: got 1 at cycle %0d expected 0", cyc);
      end
      if (cyc == 10) begin
        vectors++;
        if (stall_req !== 1'b0) begin
          miscompares++;
          $display("FAIL cancel stall_req: got %b expected 0", stall_req);
        end
      end
    end
    test_op("after_cancel", 1'b0, 32'd1000, 32'd33, 32'd10, 32'd30);
    test_idle("after_cancel");
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      start = 1'b1; cancel = 1'b0;
      if (cyc == 0) begin
        signed_div = 1'b1; a = 32'hDEADBEEF; b = 32'd12345;
      end
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    #1;
    vectors++;
    if ({stall_req, valid, hi, lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: stall_req=%b valid=%b hi=%h lo=%h expected all 0", stall_req, valid, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    lastHi = '0; lastLo = '0;
    test_op("post_reset", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7);
    test_op("back_to_back_9_4", 1'b0, 32'd9, 32'd4, 32'd1, 32'd2);
    test_idle("back_to_back");
  endtask

  task automatic test_random();
    logic [W-1:0] specials [4] = '{32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF};
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] exp;
    bit sd;
    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = specials[$urandom_range(0, 3)];
        2:       rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      exp = ref_div(sd, ra, rb);
      test_op($sformatf("rand%0d", i), sd, ra, rb, exp[2*W-1:W], exp[W-1:0]);
      if (1'($urandom)) test_idle($sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
